// File: rtl/edid_ddc_arbiter.sv
// Purpose : shares one 8x256 synchronous EDID RAM between two read-only DDC engines and a host
//           write port, and sequences HPD low/high around EDID rewrites.
// Latency : read grant is combinational; rd_valid/rd_data follow 2 cycles after rd_gnt.
// Backpressure: requesters hold rd_req/wr_req until granted; a host write in LOCK stalls both reads.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rd_req/rd_addr/rd_gnt (0/1)     DDC read request, word offset, combinational grant
//   rd_valid/rd_data (0/1)          registered read return, data held until next valid
//   pwr5v (0/1) in, hpd (0/1) out   +5V detect (async), registered hot-plug detect
//   upd_start/upd_end/upd_busy      host update sequencing
//   wr_req/wr_addr/wr_data/wr_ack   host write port (honoured only while locked)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   synchronous RAM port
module edid_ddc_arbiter #(
    parameter int HPD_LOW_CYCLES = 10_000_000,
    parameter int CNT_W          = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req0,
    input  logic [7:0]       rd_addr0,
    output logic             rd_gnt0,
    output logic             rd_valid0,
    output logic [7:0]       rd_data0,
    input  logic             rd_req1,
    input  logic [7:0]       rd_addr1,
    output logic             rd_gnt1,
    output logic             rd_valid1,
    output logic [7:0]       rd_data1,
    input  logic             pwr5v0,
    input  logic             pwr5v1,
    output logic             hpd0,
    output logic             hpd1,
    input  logic             upd_start,
    input  logic             upd_end,
    output logic             upd_busy,
    input  logic             wr_req,
    input  logic [7:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_LOCK = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(HPD_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             last_gnt;
    logic             rd_pend0, rd_pend1;
    logic [1:0]       pwr_s1, pwr_s2;
    logic             wr_sel, pick1;

    // ------------------------------------------------------------------
    // Update sequencer. cnt measures HPD-low time from reset or LOCK
    // entry; it is deliberately not cleared on LOCK->WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (state)
            S_INIT: begin
                cnt_nxt = cnt_inc;
                if (cnt == LOW_LAST) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                // upd_end in the same cycle as upd_start is dropped
                if (upd_start) begin
                    state_nxt = S_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_LOCK: begin
                cnt_nxt = cnt_inc;
                if (upd_end) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                cnt_nxt = cnt_inc;
                if (cnt >= LOW_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign upd_busy = rst_n && (state != S_IDLE);

    // ------------------------------------------------------------------
    // Memory port arbitration: host write (locked only) beats reads;
    // contending reads go to the port not granted last.
    // ------------------------------------------------------------------
    assign wr_sel = rst_n && (state == S_LOCK) && wr_req;
    assign pick1  = rd_req1 && (!rd_req0 || !last_gnt);

    assign wr_ack    = wr_sel;
    assign rd_gnt1   = rst_n && !wr_sel && pick1;
    assign rd_gnt0   = rst_n && !wr_sel && rd_req0 && !pick1;
    assign mem_en    = wr_sel || rd_gnt0 || rd_gnt1;
    assign mem_we    = wr_sel;
    assign mem_addr  = wr_sel  ? wr_addr  :
                       rd_gnt1 ? rd_addr1 :
                       rd_gnt0 ? rd_addr0 : 8'h00;
    assign mem_wdata = wr_sel ? wr_data : 8'h00;

    // Read return: RAM answers the cycle after the grant; capture at the
    // end of that cycle so rd_valid shows two cycles after rd_gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            rd_pend0  <= 1'b0;
            rd_pend1  <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            rd_data0  <= 8'h00;
            rd_data1  <= 8'h00;
        end else begin
            if (rd_gnt0 || rd_gnt1) last_gnt <= rd_gnt1;
            rd_pend0  <= rd_gnt0;
            rd_pend1  <= rd_gnt1;
            rd_valid0 <= rd_pend0;
            rd_valid1 <= rd_pend1;
            if (rd_pend0) rd_data0 <= mem_rdata;
            if (rd_pend1) rd_data1 <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // HPD: +5V detect through a 2-flop synchronizer, gated by IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_s1 <= 2'b00;
            pwr_s2 <= 2'b00;
            hpd0   <= 1'b0;
            hpd1   <= 1'b0;
        end else begin
            pwr_s1 <= {pwr5v1, pwr5v0};
            pwr_s2 <= pwr_s1;
            hpd0   <= (state == S_IDLE) && pwr_s2[0];
            hpd1   <= (state == S_IDLE) && pwr_s2[1];
        end
    end

endmodule

// File: tb/tb_edid_ddc_arbiter.sv
// Purpose : randomized self-checking bench for edid_ddc_arbiter against a behavioural model.
// Latency : model expects rd_valid two cycles after each grant, hpd three cycles after +5V.
// Backpressure: bench holds requests as a DDC engine/host would; grants are predicted per cycle.
module tb_edid_ddc_arbiter;

    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req0 = 1'b0, rd_req1 = 1'b0;
    logic [7:0] rd_addr0 = 8'h00, rd_addr1 = 8'h00;
    logic       rd_gnt0, rd_gnt1, rd_valid0, rd_valid1;
    logic [7:0] rd_data0, rd_data1;
    logic       pwr5v0 = 1'b0, pwr5v1 = 1'b0;
    logic       hpd0, hpd1;
    logic       upd_start = 1'b0, upd_end = 1'b0, upd_busy;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
    logic       wr_ack, mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    always #5 clk = ~clk;

    edid_ddc_arbiter #(.HPD_LOW_CYCLES(H), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req0(rd_req0), .rd_addr0(rd_addr0), .rd_gnt0(rd_gnt0), .rd_valid0(rd_valid0), .rd_data0(rd_data0),
        .rd_req1(rd_req1), .rd_addr1(rd_addr1), .rd_gnt1(rd_gnt1), .rd_valid1(rd_valid1), .rd_data1(rd_data1),
        .pwr5v0(pwr5v0), .pwr5v1(pwr5v1), .hpd0(hpd0), .hpd1(hpd1),
        .upd_start(upd_start), .upd_end(upd_end), .upd_busy(upd_busy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous EDID RAM seen by the DUT
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- behavioural model ----------------
    typedef enum {P_INIT, P_IDLE, P_LOCK, P_WAIT} phase_t;
    typedef struct { int due; int port; logic [7:0] d; } ret_t;

    phase_t     ph;
    int         t;            // cycles since reset release
    int         low_start;    // cycle HPD-low period began
    int         m_last;       // last port granted a read
    int         g;            // predicted grant this cycle (-1 none)
    logic       exp_wack;
    ret_t       rq[$];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_d [2];
    logic       idle_hist [16384];
    logic [1:0] pwr_hist  [16384];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        ph = P_INIT; t = 0; low_start = 0; m_last = 1;
        rq.delete();
        exp_d[0] = 8'h00; exp_d[1] = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  {6'b0, rd_gnt1, rd_gnt0}, 8'h00);
        check({tag, "_vld"},  {6'b0, rd_valid1, rd_valid0}, 8'h00);
        check({tag, "_d0"},   rd_data0, 8'h00);
        check({tag, "_d1"},   rd_data1, 8'h00);
        check({tag, "_hpd"},  {6'b0, hpd1, hpd0}, 8'h00);
        check({tag, "_ctl"},  {4'b0, upd_busy, wr_ack, mem_en, mem_we}, 8'h00);
        check({tag, "_addr"}, mem_addr, 8'h00);
        check({tag, "_wdat"}, mem_wdata, 8'h00);
    endtask

    task automatic check_outputs();
        logic [1:0] exp_v;
        logic [1:0] exp_hpd;
        exp_wack = (ph == P_LOCK) && wr_req;
        g = -1;
        if (!exp_wack) begin
            if (rd_req0 && rd_req1) g = (m_last == 1) ? 0 : 1;
            else if (rd_req0)       g = 0;
            else if (rd_req1)       g = 1;
        end
        check("wr_ack",  8'(wr_ack),  8'(exp_wack));
        check("rd_gnt0", 8'(rd_gnt0), 8'(g == 0));
        check("rd_gnt1", 8'(rd_gnt1), 8'(g == 1));
        check("mem_en",  8'(mem_en),  8'(exp_wack || g >= 0));
        check("mem_we",  8'(mem_we),  8'(exp_wack));
        if (exp_wack) begin
            check("wr_addr", mem_addr, wr_addr);
            check("wr_dat",  mem_wdata, wr_data);
        end else if (g == 0) check("rd_addr0", mem_addr, rd_addr0);
        else if (g == 1)     check("rd_addr1", mem_addr, rd_addr1);

        exp_v = 2'b00;
        while (rq.size() > 0 && rq[0].due == t) begin
            exp_v[rq[0].port] = 1'b1;
            exp_d[rq[0].port] = rq[0].d;
            void'(rq.pop_front());
        end
        check("rd_valid0", 8'(rd_valid0), 8'(exp_v[0]));
        check("rd_valid1", 8'(rd_valid1), 8'(exp_v[1]));
        check("rd_data0",  rd_data0, exp_d[0]);
        check("rd_data1",  rd_data1, exp_d[1]);

        // hpd: IDLE in previous cycle, +5V seen three cycles ago
        exp_hpd = (t >= 3 && idle_hist[t-1]) ? pwr_hist[t-3] : 2'b00;
        check("hpd0", 8'(hpd0), 8'(exp_hpd[0]));
        check("hpd1", 8'(hpd1), 8'(exp_hpd[1]));
        check("upd_busy", 8'(upd_busy), 8'(ph != P_IDLE));
    endtask

    task automatic advance_model();
        ret_t r;
        idle_hist[t] = (ph == P_IDLE);
        pwr_hist[t]  = {pwr5v1, pwr5v0};
        if (exp_wack) ref_mem[wr_addr] = wr_data;
        if (g >= 0) begin
            r.due = t + 2; r.port = g;
            r.d = (g == 0) ? ref_mem[rd_addr0] : ref_mem[rd_addr1];
            rq.push_back(r);
            m_last = g;
        end
        case (ph)
            P_INIT: if (t - low_start == H - 1) ph = P_IDLE;
            P_IDLE: if (upd_start) begin ph = P_LOCK; low_start = t + 1; end
            P_LOCK: if (upd_end) ph = P_WAIT;
            P_WAIT: if (t - low_start >= H - 1) ph = P_IDLE;
            default: ph = P_INIT;
        endcase
        t++;
    endtask

    // one clock cycle: inputs already driven at posedge+1
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req0 = 0; rd_req1 = 0; wr_req = 0; upd_start = 0; upd_end = 0;
    endtask

    task automatic rand_reads();
        rd_req0  = 1'($urandom_range(0, 1));
        rd_req1  = 1'($urandom_range(0, 1));
        rd_addr0 = 8'($urandom);
        rd_addr1 = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        // 1: reset state, INIT hold, hpd0 follows +5V, hpd1 stays low
        pwr5v0 = 1; pwr5v1 = 0;
        rd_req0 = 1; wr_req = 1;
        #2;
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1;
        model_reset();
        repeat (24) cycle();

        // 2: both ports held, alternate grants
        rd_req0 = 1; rd_req1 = 1; rd_addr0 = 8'h00; rd_addr1 = 8'h80;
        repeat (8) cycle();
        rd_addr0 = 8'hFF; rd_addr1 = 8'hFE;
        repeat (4) cycle();
        idle_inputs();
        repeat (3) cycle();

        // 3/4: update with write to 0x7F while port 0 reads, upd_end 3 cycles later
        upd_start = 1; rd_req0 = 1; rd_addr0 = 8'h7F;
        cycle();
        upd_start = 0; wr_req = 1; wr_addr = 8'h7F; wr_data = 8'hA5;
        cycle();
        wr_req = 0; rd_req0 = 0;
        cycle();
        upd_end = 1;
        cycle();
        upd_end = 0;
        for (int i = 0; i < 20; i++) begin
            rand_reads();
            cycle();
        end
        idle_inputs();
        rd_req1 = 1; rd_addr1 = 8'h7F;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // 5: host write outside LOCK is ignored
        wr_req = 1; wr_addr = 8'h10; wr_data = ~ref_mem[8'h10];
        repeat (3) cycle();
        wr_req = 0; rd_req0 = 1; rd_addr0 = 8'h10;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // start and end together in IDLE: end is dropped, stays locked
        upd_start = 1; upd_end = 1;
        cycle();
        upd_start = 0; upd_end = 0;
        for (int i = 0; i < 20; i++) begin
            rand_reads();
            wr_req = 1'($urandom_range(0, 1)); wr_addr = 8'($urandom); wr_data = 8'($urandom);
            cycle();
        end

        // 6: async reset during LOCK
        #2;
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        idle_inputs();
        pwr5v1 = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        repeat (22) cycle();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rand_reads();
            upd_start = ($urandom_range(0, 99) < 4);
            upd_end   = ($urandom_range(0, 99) < 10);
            wr_req    = 1'($urandom_range(0, 1));
            wr_addr   = 8'($urandom);
            wr_data   = 8'($urandom);
            if ($urandom_range(0, 99) < 2) pwr5v0 = ~pwr5v0;
            if ($urandom_range(0, 99) < 2) pwr5v1 = ~pwr5v1;
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
